// File: rtl/cam_seq_pkg.sv
// Shared definitions for the OV5640 power-up sequencer: state encoding and
// default cycle counts for a 25 MHz control clock.
package cam_seq_pkg;

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_PWDN      = 3'd1,
        S_RESETB    = 3'd2,
        S_SCCB_WAIT = 3'd3,
        S_CFG       = 3'd4,
        S_RUN       = 3'd5,
        S_FAIL      = 3'd6
    } seq_state_e;

    localparam int unsigned DEF_LOCK_STABLE_CYC = 1024;
    localparam int unsigned DEF_PWDN_CYC        = 250000;   // 10 ms
    localparam int unsigned DEF_RESETB_CYC      = 50000;    // 2 ms
    localparam int unsigned DEF_SCCB_DELAY_CYC  = 500000;   // 20 ms
    localparam int unsigned DEF_CFG_TIMEOUT_CYC = 2500000;  // 100 ms
    localparam int unsigned DEF_MAX_RETRY       = 3;
    localparam int unsigned DEF_CNT_W           = 24;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for bringing asynchronous level signals into clk.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cam_pwr_seq.sv
// OV5640 power-up/reset sequencer: waits for a stable PLL lock, walks PWDN and
// RESETB in order, launches SCCB configuration and releases the datapath reset.
module cam_pwr_seq
    import cam_seq_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int unsigned PWDN_CYC        = DEF_PWDN_CYC,
    parameter int unsigned RESETB_CYC      = DEF_RESETB_CYC,
    parameter int unsigned SCCB_DELAY_CYC  = DEF_SCCB_DELAY_CYC,
    parameter int unsigned CFG_TIMEOUT_CYC = DEF_CFG_TIMEOUT_CYC,
    parameter int unsigned MAX_RETRY       = DEF_MAX_RETRY,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       cfg_done,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       cfg_start,
    output logic       sys_rst,
    output logic       seq_ready,
    output logic       cfg_err,
    output logic [2:0] seq_state
);

    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] PWDN_LAST   = CNT_W'(PWDN_CYC - 1);
    localparam logic [CNT_W-1:0] RESETB_LAST = CNT_W'(RESETB_CYC - 1);
    localparam logic [CNT_W-1:0] SCCB_LAST   = CNT_W'(SCCB_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] CFG_LAST    = CNT_W'(CFG_TIMEOUT_CYC - 1);
    localparam logic [RTY_W-1:0] RETRY_LIMIT = RTY_W'(MAX_RETRY);

    logic             lk_s;
    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d, retry_inc;

    logic cam_pwdn_q, cam_rst_n_q, cfg_start_q, sys_rst_q, seq_ready_q, cfg_err_q;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (lk_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        retry_d   = retry_q;
        retry_inc = retry_q + RTY_W'(1);
        case (state_q)
            S_WAIT_LOCK: begin
                if (!lk_s)
                    cnt_d = '0;
                else if (cnt_q == LOCK_LAST)
                    state_d = S_PWDN;
            end
            S_PWDN:      if (cnt_q == PWDN_LAST)   state_d = S_RESETB;
            S_RESETB:    if (cnt_q == RESETB_LAST) state_d = S_SCCB_WAIT;
            S_SCCB_WAIT: if (cnt_q == SCCB_LAST)   state_d = S_CFG;
            S_CFG: begin
                // a late cfg_done landing on the timeout cycle still counts
                if (cfg_done)
                    state_d = S_RUN;
                else if (cnt_q == CFG_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc < RETRY_LIMIT) ? S_PWDN : S_FAIL;
                end
            end
            S_RUN, S_FAIL: ;
            default: state_d = S_WAIT_LOCK;
        endcase

        if (!lk_s && (state_q inside {S_PWDN, S_RESETB, S_SCCB_WAIT, S_CFG, S_RUN}))
            state_d = S_WAIT_LOCK;
        if (state_d != state_q)
            cnt_d = '0;
        if (state_d == S_WAIT_LOCK)
            retry_d = '0;
    end

    // Outputs are decoded from the next state so they change with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_WAIT_LOCK;
            cnt_q       <= '0;
            retry_q     <= '0;
            cam_pwdn_q  <= 1'b1;
            cam_rst_n_q <= 1'b0;
            cfg_start_q <= 1'b0;
            sys_rst_q   <= 1'b1;
            seq_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            cam_pwdn_q  <= (state_d == S_WAIT_LOCK) || (state_d == S_PWDN) || (state_d == S_FAIL);
            cam_rst_n_q <= (state_d == S_SCCB_WAIT) || (state_d == S_CFG) || (state_d == S_RUN);
            cfg_start_q <= (state_d == S_CFG) && (state_q == S_SCCB_WAIT);
            sys_rst_q   <= (state_d != S_RUN);
            seq_ready_q <= (state_d == S_RUN);
            cfg_err_q   <= (state_d == S_FAIL);
        end
    end

    assign cam_pwdn  = cam_pwdn_q;
    assign cam_rst_n = cam_rst_n_q;
    assign cfg_start = cfg_start_q;
    assign sys_rst   = sys_rst_q;
    assign seq_ready = seq_ready_q;
    assign cfg_err   = cfg_err_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Directed bench for cam_pwr_seq with shortened cycle parameters; cycle 0 is
// the first cycle in which the synchronised lock is high.
module tb_cam_pwr_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       cfg_done = 1'b0;
    logic       cam_pwdn, cam_rst_n, cfg_start, sys_rst, seq_ready, cfg_err;
    logic [2:0] seq_state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int starts = 0;

    // output flag groups {cam_pwdn, cam_rst_n, cfg_start, sys_rst, seq_ready, cfg_err}
    localparam logic [5:0] F_IDLE  = 6'b100100;
    localparam logic [5:0] F_RSTB  = 6'b000100;
    localparam logic [5:0] F_CFG   = 6'b010100;
    localparam logic [5:0] F_START = 6'b011100;
    localparam logic [5:0] F_RUN   = 6'b010010;
    localparam logic [5:0] F_FAIL  = 6'b100101;

    typedef struct packed {
        logic [7:0] cyc;
        logic       done;
        logic [2:0] st;
        logic [5:0] f;
    } vec_t;

    vec_t nom [13];

    always #5 clk = ~clk;

    cam_pwr_seq #(
        .LOCK_STABLE_CYC (8),
        .PWDN_CYC        (4),
        .RESETB_CYC      (6),
        .SCCB_DELAY_CYC  (10),
        .CFG_TIMEOUT_CYC (20),
        .MAX_RETRY       (2),
        .CNT_W           (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .cfg_done   (cfg_done),
        .cam_pwdn   (cam_pwdn),
        .cam_rst_n  (cam_rst_n),
        .cfg_start  (cfg_start),
        .sys_rst    (sys_rst),
        .seq_ready  (seq_ready),
        .cfg_err    (cfg_err),
        .seq_state  (seq_state)
    );

    function automatic logic [31:0] outs();
        return {23'd0, seq_state, cam_pwdn, cam_rst_n, cfg_start, sys_rst, seq_ready, cfg_err};
    endfunction

    function automatic logic [31:0] eo(input logic [2:0] st, input logic [5:0] f);
        return {23'd0, st, f};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cfg_done = 1'b0;
        cyc++;
        if (cfg_start) starts++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pll_locked = 1'b0;
        cfg_done = 1'b0;
        #1;
        check("reset_state", outs(), eo(3'd0, F_IDLE));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // two synchroniser edges later lk_s is high: that cycle is cycle 0
    task automatic lock_up();
        pll_locked = 1'b1;
        tick();
        tick();
        cyc = 0;
        starts = 0;
    endtask

    task automatic run_nominal(input string tag);
        foreach (nom[i]) begin
            goto(int'(nom[i].cyc));
            check($sformatf("%s_c%0d", tag, nom[i].cyc), outs(), eo(nom[i].st, nom[i].f));
            cfg_done = nom[i].done;
        end
        check({tag, "_start_count"}, starts, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        nom[0]  = '{8'd0,  1'b0, 3'd0, F_IDLE};
        nom[1]  = '{8'd7,  1'b0, 3'd0, F_IDLE};
        nom[2]  = '{8'd8,  1'b0, 3'd1, F_IDLE};
        nom[3]  = '{8'd11, 1'b0, 3'd1, F_IDLE};
        nom[4]  = '{8'd12, 1'b0, 3'd2, F_RSTB};
        nom[5]  = '{8'd17, 1'b0, 3'd2, F_RSTB};
        nom[6]  = '{8'd18, 1'b0, 3'd3, F_CFG};
        nom[7]  = '{8'd27, 1'b0, 3'd3, F_CFG};
        nom[8]  = '{8'd28, 1'b0, 3'd4, F_START};
        nom[9]  = '{8'd29, 1'b0, 3'd4, F_CFG};
        nom[10] = '{8'd31, 1'b1, 3'd4, F_CFG};
        nom[11] = '{8'd32, 1'b0, 3'd5, F_RUN};
        nom[12] = '{8'd40, 1'b0, 3'd5, F_RUN};

        // nominal sequence, then lock loss in S_RUN and a full rerun
        do_reset();
        lock_up();
        run_nominal("nom");
        pll_locked = 1'b0;
        goto(42);
        check("lossrun_c42_still_run", outs(), eo(3'd5, F_RUN));
        goto(43);
        check("lossrun_c43_wait", outs(), eo(3'd0, F_IDLE));
        goto(45);
        lock_up();
        run_nominal("relock");

        // lock glitch while the stabilisation counter is at 5
        do_reset();
        lock_up();
        goto(5);
        pll_locked = 1'b0;
        goto(8);
        check("glitch_c8_wait", outs(), eo(3'd0, F_IDLE));
        pll_locked = 1'b1;
        goto(17);
        check("glitch_c17_wait", outs(), eo(3'd0, F_IDLE));
        goto(18);
        check("glitch_c18_pwdn", outs(), eo(3'd1, F_IDLE));

        // timeout on first attempt, success on the retry
        do_reset();
        lock_up();
        goto(28);
        check("retry_start1", outs(), eo(3'd4, F_START));
        goto(47);
        check("retry_c47_cfg", outs(), eo(3'd4, F_CFG));
        goto(48);
        check("retry_c48_pwdn", outs(), eo(3'd1, F_IDLE));
        goto(52);
        check("retry_c52_resetb", outs(), eo(3'd2, F_RSTB));
        goto(68);
        check("retry_start2", outs(), eo(3'd4, F_START));
        goto(70);
        cfg_done = 1'b1;
        goto(71);
        check("retry_run", outs(), eo(3'd5, F_RUN));
        check("retry_start_count", starts, 2);

        // no cfg_done at all: two timeouts end in S_FAIL
        do_reset();
        lock_up();
        goto(87);
        check("fail_c87_cfg", outs(), eo(3'd4, F_CFG));
        goto(88);
        check("fail_c88_fail", outs(), eo(3'd6, F_FAIL));
        pll_locked = 1'b0;
        goto(92);
        pll_locked = 1'b1;
        goto(96);
        check("fail_lock_toggle", outs(), eo(3'd6, F_FAIL));
        cfg_done = 1'b1;
        goto(97);
        check("fail_cfg_done_ignored", outs(), eo(3'd6, F_FAIL));
        #2;
        rst = 1'b1;
        #1;
        check("fail_rst_clears", outs(), eo(3'd0, F_IDLE));
        @(negedge clk);
        rst = 1'b0;

        // cfg_done on the timeout cycle counts as success
        do_reset();
        lock_up();
        goto(46);
        check("edge_c46_cfg", outs(), eo(3'd4, F_CFG));
        goto(47);
        cfg_done = 1'b1;
        goto(48);
        check("edge_done_on_timeout", outs(), eo(3'd5, F_RUN));

        // lock loss wins over cfg_done in the same cycle
        do_reset();
        lock_up();
        goto(29);
        pll_locked = 1'b0;
        goto(31);
        check("loss_vs_done_c31", outs(), eo(3'd4, F_CFG));
        cfg_done = 1'b1;
        goto(32);
        check("loss_vs_done_c32", outs(), eo(3'd0, F_IDLE));

        // asynchronous reset pulse in the middle of S_RESETB
        do_reset();
        lock_up();
        goto(14);
        check("arst_c14_resetb", outs(), eo(3'd2, F_RSTB));
        #2;
        rst = 1'b1;
        #1;
        check("arst_immediate", outs(), eo(3'd0, F_IDLE));
        #1;
        rst = 1'b0;
        lock_up();
        run_nominal("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
